// File: rtl/sysreg_commit.sv
// Execute-stage system-register bank: SR1, PSR, PPC, IDTR.
// Commits read-modify-write results from the field-manipulation unit and
// sequences exception entry (save, then modify) and IRET restore.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | accepting writes; waiting for exception or IRET request
// EXC_SAVE  | PSR/PPC hold the saved context; SR1 not yet modified
// EXC_MOD   | SR1 IM/CMOD cleared; entry completes on the next edge
// IRET      | SR1 restored from PSR; restore completes on the next edge
module sysreg_commit #(
  parameter logic [31:0] SR1_WMASK = 32'h0000_0067,
  parameter logic [31:0] SR1_RESET = 32'h0000_0000
) (
  input  logic        iCLOCK,
  input  logic        inRESET,
  input  logic        iWR_VALID,
  output logic        oWR_BUSY,
  input  logic [1:0]  iWR_ADDR,
  input  logic [31:0] iWR_DATA,
  input  logic        iEXCEPT_VALID,
  input  logic [31:0] iEXCEPT_PC,
  input  logic        iIRET_VALID,
  output logic        oEXCEPT_DONE,
  output logic        oIRET_VALID,
  output logic [31:0] oIRET_PC,
  output logic        oWB_VALID,
  output logic [1:0]  oWB_ADDR,
  output logic [31:0] oWB_DATA,
  output logic [31:0] oSR1,
  output logic [31:0] oPSR,
  output logic [31:0] oPPC,
  output logic [31:0] oIDTR
);

  // IM (bit 2) and CMOD (bits 6:5) are forced to zero on exception entry.
  localparam logic [31:0] EXC_CLR = 32'h0000_0064;

  localparam logic [1:0] ADDR_SR1  = 2'd0;
  localparam logic [1:0] ADDR_PSR  = 2'd1;
  localparam logic [1:0] ADDR_PPC  = 2'd2;
  localparam logic [1:0] ADDR_IDTR = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_EXC_SAVE = 2'd1,
    ST_EXC_MOD  = 2'd2,
    ST_IRET     = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] sr1_q, sr1_d;
  logic [31:0] psr_q, psr_d;
  logic [31:0] ppc_q, ppc_d;
  logic [31:0] idtr_q, idtr_d;
  logic [31:0] iret_pc_q, iret_pc_d;
  logic        except_done_q, except_done_d;
  logic        iret_valid_q, iret_valid_d;
  logic        wb_valid_q, wb_valid_d;
  logic [1:0]  wb_addr_q, wb_addr_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic        wr_busy;
  logic [31:0] wr_store;

  // Next-state, register updates and write-accept decode.
  always_comb begin
    state_d       = state_q;
    sr1_d         = sr1_q;
    psr_d         = psr_q;
    ppc_d         = ppc_q;
    idtr_d        = idtr_q;
    iret_pc_d     = iret_pc_q;
    except_done_d = 1'b0;
    iret_valid_d  = 1'b0;
    wb_valid_d    = 1'b0;
    wb_addr_d     = wb_addr_q;
    wb_data_d     = wb_data_q;

    // Busy includes same-cycle sequence requests so they win over a write.
    wr_busy  = (state_q != ST_IDLE) || iEXCEPT_VALID || iIRET_VALID;
    wr_store = (iWR_ADDR == ADDR_SR1) ? (iWR_DATA & SR1_WMASK) : iWR_DATA;

    case (state_q)
      ST_IDLE: begin
        if (iEXCEPT_VALID) begin
          state_d = ST_EXC_SAVE;
          psr_d   = sr1_q;
          ppc_d   = iEXCEPT_PC;
        end else if (iIRET_VALID) begin
          state_d   = ST_IRET;
          sr1_d     = psr_q & SR1_WMASK;
          iret_pc_d = ppc_q;
        end else if (iWR_VALID) begin
          wb_valid_d = 1'b1;
          wb_addr_d  = iWR_ADDR;
          wb_data_d  = wr_store;
          case (iWR_ADDR)
            ADDR_SR1:  sr1_d  = wr_store;
            ADDR_PSR:  psr_d  = wr_store;
            ADDR_PPC:  ppc_d  = wr_store;
            ADDR_IDTR: idtr_d = wr_store;
          endcase
        end
      end
      ST_EXC_SAVE: begin
        state_d = ST_EXC_MOD;
        sr1_d   = sr1_q & ~EXC_CLR;
      end
      ST_EXC_MOD: begin
        state_d       = ST_IDLE;
        except_done_d = 1'b1;
      end
      ST_IRET: begin
        state_d      = ST_IDLE;
        iret_valid_d = 1'b1;
      end
    endcase
  end

  // State and register flops with synchronous active-low reset.
  always_ff @(posedge iCLOCK) begin
    if (!inRESET) begin
      state_q       <= ST_IDLE;
      sr1_q         <= SR1_RESET & SR1_WMASK;
      psr_q         <= 32'h0;
      ppc_q         <= 32'h0;
      idtr_q        <= 32'h0;
      iret_pc_q     <= 32'h0;
      except_done_q <= 1'b0;
      iret_valid_q  <= 1'b0;
      wb_valid_q    <= 1'b0;
      wb_addr_q     <= 2'd0;
      wb_data_q     <= 32'h0;
    end else begin
      state_q       <= state_d;
      sr1_q         <= sr1_d;
      psr_q         <= psr_d;
      ppc_q         <= ppc_d;
      idtr_q        <= idtr_d;
      iret_pc_q     <= iret_pc_d;
      except_done_q <= except_done_d;
      iret_valid_q  <= iret_valid_d;
      wb_valid_q    <= wb_valid_d;
      wb_addr_q     <= wb_addr_d;
      wb_data_q     <= wb_data_d;
    end
  end

  assign oWR_BUSY     = wr_busy;
  assign oEXCEPT_DONE = except_done_q;
  assign oIRET_VALID  = iret_valid_q;
  assign oIRET_PC     = iret_pc_q;
  assign oWB_VALID    = wb_valid_q;
  assign oWB_ADDR     = wb_addr_q;
  assign oWB_DATA     = wb_data_q;
  assign oSR1         = sr1_q;
  assign oPSR         = psr_q;
  assign oPPC         = ppc_q;
  assign oIDTR        = idtr_q;

endmodule

// File: doc/sysreg_commit.md
Name: sysreg_commit

Overview:
- Execute-stage system-register bank, directly downstream of the combinational system-register field-manipulation unit.
- Latches that unit's 32-bit read-modify-write result into the architectural system registers SR1, PSR, PPC and IDTR.
- Runs the multi-cycle exception-entry save/modify sequence and the IRET restore.
- Drives current register values back to the field-manipulation unit and to the rest of the core.

Parameters:
- SR1_WMASK, 32'h0000_0067, writable SR1 bits (MMUMOD[1:0], IM[2], CMOD[6:5]); all other SR1 bits are stored and read as 0.
- SR1_RESET, 32'h0000_0000, SR1 value after reset.

Ports:
- iCLOCK  in  1  clock, all state on rising edge.
- inRESET  in  1  synchronous active-low reset, sampled on the rising edge of iCLOCK.
- iWR_VALID  in  1  write request.
- oWR_BUSY  out  1  write cannot be accepted this cycle.
- iWR_ADDR  in  2  target: 0=SR1, 1=PSR, 2=PPC, 3=IDTR.
- iWR_DATA  in  32  full new register value (field-manipulation unit output).
- iEXCEPT_VALID  in  1  exception/interrupt entry request (single-cycle pulse).
- iEXCEPT_PC  in  32  PC to save.
- iIRET_VALID  in  1  return-from-interrupt request (single-cycle pulse).
- oEXCEPT_DONE  out  1  one-cycle pulse when entry completes.
- oIRET_VALID  out  1  one-cycle pulse when restore completes.
- oIRET_PC  out  32  PPC value at restore; valid with oIRET_VALID.
- oWB_VALID  out  1  one-cycle pulse for a committed write.
- oWB_ADDR  out  2  address of the committed write.
- oWB_DATA  out  32  value actually stored, after masking.
- oSR1, oPSR, oPPC, oIDTR  out  32 each  current register contents.

Behaviour:
- Reset (inRESET=0 at the edge):
  - SR1=SR1_RESET; PSR, PPC, IDTR = 0.
  - FSM=IDLE.
  - All pulse outputs 0; oIRET_PC=0; oWB_ADDR=0; oWB_DATA=0; oWR_BUSY=0.
  - Reset mid-sequence aborts the sequence with no partial update beyond what already committed.
- FSM states: IDLE, EXC_SAVE, EXC_MOD, IRET.
- oWR_BUSY = (FSM != IDLE) or iEXCEPT_VALID or iIRET_VALID. This output is combinational.
- Write accept:
  - Accepted when iWR_VALID=1 and oWR_BUSY=0.
  - The register updates at that edge and is visible on oSRx the next cycle.
  - SR1 stores iWR_DATA & SR1_WMASK; the other registers store iWR_DATA unmodified.
  - oWB_VALID/ADDR/DATA pulse in the cycle after the accept edge (latency 1); oWB_DATA is the stored value.
  - A write presented while busy is not accepted. The requester holds it until accepted; this block does not queue.
- Priority among requests in the same IDLE cycle: iEXCEPT_VALID > iIRET_VALID > write. The losers are ignored (write: not accepted; IRET: dropped).
- Exception entry, from IDLE on iEXCEPT_VALID:
  - Edge 1 -> EXC_SAVE: PSR<=SR1, PPC<=iEXCEPT_PC.
  - Edge 2 -> EXC_MOD: SR1[2] (IM) <= 0, SR1[6:5] (CMOD) <= 2'b00; MMUMOD unchanged.
  - Edge 3 -> IDLE, with oEXCEPT_DONE=1 during the cycle after edge 3.
- IRET, from IDLE on iIRET_VALID:
  - Edge 1 -> IRET: SR1<=PSR & SR1_WMASK; oIRET_PC registered <= PPC.
  - Edge 2 -> IDLE, with oIRET_VALID=1 during the cycle after edge 2.
- Requests arriving outside IDLE:
  - iEXCEPT_VALID or iIRET_VALID asserted outside IDLE is ignored; upstream guarantees none arrive.
  - A write never lands during a sequence.
- Back-to-back writes are accepted on consecutive cycles. Sustained throughput is 1 write per cycle, with a matching oWB_VALID pulse for each.
- Data widths are all 32-bit; no arithmetic.

Test Plan:
- Reset, then idle -> oSR1=0, oPSR=0, oPPC=0, oIDTR=0, oWR_BUSY=0, no pulses.
- Write SR1 with iWR_DATA=32'hFFFF_FFFF -> next cycle oSR1=32'h0000_0067; oWB_VALID=1, oWB_ADDR=0, oWB_DATA=32'h67.
- SR1=32'h67, then iEXCEPT_VALID with iEXCEPT_PC=32'h0000_1000 -> PSR=32'h67, PPC=32'h1000, then SR1=32'h03; oEXCEPT_DONE pulses 3 cycles after the request; oWR_BUSY high for 3 cycles.
- IRET after the previous scenario -> SR1=32'h67; oIRET_VALID pulses 2 cycles after the request with oIRET_PC=32'h1000.
- iWR_VALID (IDTR, 32'hDEAD_BEEF) in the same cycle as iEXCEPT_VALID -> write not accepted, exception runs; write held and accepted on the first IDLE cycle; then IDTR=32'hDEAD_BEEF.
- inRESET=0 while in EXC_MOD, after PSR has been saved -> all registers return to reset values; no oEXCEPT_DONE pulse.
